// File: rtl/haar_database_arbiter.sv
// Shares one cascade-database ROM among several window-inspection engines: grants one owner,
// streams all TOTAL words with aligned indices/end flags, then releases. Option: HAAR_ARB_FIXED_PRIORITY_EN.
module haar_database_arbiter #(
  parameter int NUM_REQUESTERS           = 4,
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_CLASSIFIERS          = 2,
  parameter int NUM_TREES                = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] i_database_request,
  output logic [NUM_REQUESTERS-1:0] o_grant,
  output logic                      o_rom_ren,
  output logic [DATA_WIDTH_12-1:0]  o_rom_addr,
  input  logic [DATA_WIDTH_16-1:0]  i_rom_data,
  output logic [DATA_WIDTH_16-1:0]  o_data,
  output logic                      o_data_valid,
  output logic [DATA_WIDTH_12-1:0]  o_index_database,
  output logic [DATA_WIDTH_12-1:0]  o_index_classifier,
  output logic [DATA_WIDTH_12-1:0]  o_index_tree,
  output logic                      o_end_single_classifier,
  output logic                      o_end_tree,
  output logic                      o_end_database,
  output logic                      o_busy
);

  localparam int TOTAL = NUM_PARAM_PER_CLASSIFIER * NUM_CLASSIFIERS * NUM_TREES;
  localparam int IW    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  localparam logic [DATA_WIDTH_12-1:0] LAST_LIN = DATA_WIDTH_12'(TOTAL - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_P   = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_C   = DATA_WIDTH_12'(NUM_CLASSIFIERS - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_T   = DATA_WIDTH_12'(NUM_TREES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_RELEASE} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [NUM_REQUESTERS-1:0]   r_grant;
  logic [IW-1:0]               r_owner;
  logic [IW-1:0]               r_last;
  logic [DATA_WIDTH_12-1:0]    r_lin;
  logic [DATA_WIDTH_12-1:0]    r_p;
  logic [DATA_WIDTH_12-1:0]    r_c;
  logic [DATA_WIDTH_12-1:0]    r_t;

  logic                        r_vld_p1;
  logic [DATA_WIDTH_12-1:0]    r_idx_db_p1;
  logic [DATA_WIDTH_12-1:0]    r_idx_cls_p1;
  logic [DATA_WIDTH_12-1:0]    r_idx_tree_p1;
  logic                        r_end_cls_p1;
  logic                        r_end_tree_p1;
  logic                        r_end_db_p1;

  logic                        w_start;
  logic                        w_ren;
  logic [IW-1:0]               w_pick;
  logic                        w_owner_req;
  logic                        w_end_cls;
  logic                        w_end_tree;
  logic                        w_end_db;

  // Winner selection; the loop runs from lowest to highest priority so the last hit wins.
  function automatic logic [IW-1:0] f_pick(input logic [NUM_REQUESTERS-1:0] req,
                                           input logic [IW-1:0]             last);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    sel = last;
`ifdef HAAR_ARB_FIXED_PRIORITY_EN
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      idx = IW'(k);
      if (req[idx]) sel = idx;
    end
`else
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQUESTERS);
      if (req[idx]) sel = idx;
    end
`endif
    return sel;
  endfunction

  assign w_pick      = f_pick(i_database_request, r_last);
  assign w_owner_req = i_database_request[r_owner];
  assign w_end_cls   = (r_p == LAST_P);
  assign w_end_tree  = w_end_cls && (r_c == LAST_C);
  assign w_end_db    = w_end_tree && (r_t == LAST_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_ren   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_database_request) begin
          w_start = 1'b1;
          w_next  = S_STREAM;
        end
      end
      S_STREAM: begin
        // A dropped owner request cancels this cycle's read; the word already in flight still lands.
        if (!w_owner_req) begin
          w_next = S_DRAIN;
        end else begin
          w_ren = 1'b1;
          if (r_lin == LAST_LIN) w_next = S_DRAIN;
        end
      end
      S_DRAIN:   w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQUESTERS - 1);
      r_lin   <= '0;
      r_p     <= '0;
      r_c     <= '0;
      r_t     <= '0;
    end else begin
      if (w_start) begin
        r_grant <= NUM_REQUESTERS'(1) << w_pick;
        r_owner <= w_pick;
        r_lin   <= '0;
        r_p     <= '0;
        r_c     <= '0;
        r_t     <= '0;
      end else if (w_ren) begin
        r_lin <= r_lin + 1'b1;
        if (w_end_cls) begin
          r_p <= '0;
          if (r_c == LAST_C) begin
            r_c <= '0;
            r_t <= (r_t == LAST_T) ? '0 : r_t + 1'b1;
          end else begin
            r_c <= r_c + 1'b1;
          end
        end else begin
          r_p <= r_p + 1'b1;
        end
      end
      if (r_state == S_DRAIN)   r_grant <= '0;
      if (r_state == S_RELEASE) r_last  <= r_owner;
    end
  end

  // ---- read stage -> output stage (_p1): ROM data arrives alongside these ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_idx_db_p1   <= '0;
      r_idx_cls_p1  <= '0;
      r_idx_tree_p1 <= '0;
      r_end_cls_p1  <= 1'b0;
      r_end_tree_p1 <= 1'b0;
      r_end_db_p1   <= 1'b0;
    end else begin
      r_vld_p1      <= w_ren;
      r_end_cls_p1  <= w_ren & w_end_cls;
      r_end_tree_p1 <= w_ren & w_end_tree;
      r_end_db_p1   <= w_ren & w_end_db;
      if (w_ren) begin
        r_idx_db_p1   <= r_lin;
        r_idx_cls_p1  <= r_c;
        r_idx_tree_p1 <= r_t;
      end
    end
  end

  assign o_grant                 = r_grant;
  assign o_rom_ren               = w_ren;
  assign o_rom_addr              = w_ren ? r_lin : '0;
  assign o_data                  = r_vld_p1 ? i_rom_data : '0;
  assign o_data_valid            = r_vld_p1;
  assign o_index_database        = r_idx_db_p1;
  assign o_index_classifier      = r_idx_cls_p1;
  assign o_index_tree            = r_idx_tree_p1;
  assign o_end_single_classifier = r_end_cls_p1;
  assign o_end_tree              = r_end_tree_p1;
  assign o_end_database          = r_end_db_p1;
  assign o_busy                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_haar_database_arbiter.sv
// Bench for haar_database_arbiter: session table, directed timing/reset/hold-off sequences,
// random sessions against an arbitration model, and a stream monitor deriving indices from word count.
module tb_haar_database_arbiter;
  localparam int NP    = 18;
  localparam int NC    = 2;
  localparam int NT    = 2;
  localparam int TOTAL = NP * NC * NT;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [15:0] rom_q = 16'h0000;
  logic [3:0]  o_grant;
  logic        o_rom_ren;
  logic [11:0] o_rom_addr;
  logic [15:0] o_data;
  logic        o_data_valid;
  logic [11:0] o_index_database, o_index_classifier, o_index_tree;
  logic        o_end_single_classifier, o_end_tree, o_end_database, o_busy;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int tot_words = 0;
  int k = 0;
  bit prev_v = 1'b0;
  int last = 3;

  always #5 clk = ~clk;

  haar_database_arbiter dut (
    .clk(clk), .reset(reset), .i_database_request(req), .o_grant(o_grant),
    .o_rom_ren(o_rom_ren), .o_rom_addr(o_rom_addr), .i_rom_data(rom_q),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_index_database(o_index_database),
    .o_index_classifier(o_index_classifier), .o_index_tree(o_index_tree),
    .o_end_single_classifier(o_end_single_classifier), .o_end_tree(o_end_tree),
    .o_end_database(o_end_database), .o_busy(o_busy)
  );

  function automatic logic [15:0] rom_fn(input int a);
    return 16'((a * 40503 + 12345) ^ (a << 7));
  endfunction

  always_ff @(posedge clk) if (o_rom_ren) rom_q <= rom_fn(int'(o_rom_addr));

  function automatic int pick(input logic [3:0] m, input int lst);
`ifdef HAAR_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (m[i]) return i;
`else
    for (int off = 1; off <= 4; off++) if (m[(lst + off) % 4]) return (lst + off) % 4;
`endif
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor: every valid word must match the word count since the stream began.
  always @(negedge clk) begin
    if (o_data_valid) begin
      k = prev_v ? k + 1 : 0;
      chk("mon_data",  o_data, rom_fn(k));
      chk("mon_idx",   o_index_database, k);
      chk("mon_cls",   o_index_classifier, (k / NP) % NC);
      chk("mon_tree",  o_index_tree, k / (NP * NC));
      chk("mon_flags", {o_end_single_classifier, o_end_tree, o_end_database},
          {(k % NP) == NP - 1, (k % (NP * NC)) == NP * NC - 1, k == TOTAL - 1});
      tot_words++;
    end else begin
      chk("mon_idle", {o_data, o_end_single_classifier, o_end_tree, o_end_database}, 0);
    end
    chk("mon_onehot", $onehot0(o_grant), 1);
    prev_v = o_data_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input string name, input int limit);
    int n = 0;
    do begin tick(); n++; end while (o_grant == 4'b0 && n < limit);
    chk({name, "_grant_seen"}, (o_grant != 4'b0), 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    do begin tick(); n++; end while (o_busy && n < limit);
    chk({name, "_idle_seen"}, o_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; req = 4'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_session(input string name, input logic [3:0] mask, input int hold,
                             input logic [3:0] eg, input int ew);
    int base;
    @(negedge clk); req = mask; base = tot_words;
    wait_grant(name, 200);
    chk({name, "_grant"}, o_grant, eg);
    chk({name, "_rd0"}, {o_rom_ren, o_rom_addr}, {1'b1, 12'd0});
    repeat (hold) @(posedge clk);
    @(negedge clk); req = mask & ~o_grant;
    wait_idle(name, 300);
    chk({name, "_gap_grant"}, o_grant, 0);
    chk({name, "_words"}, tot_words - base, ew);
  endtask

  typedef struct {
    logic [3:0] req;
    int         hold;
    logic [3:0] exp_grant;
    int         exp_words;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2 reset = 1'b1;
    tbl[0] = '{4'b0001, 72, 4'b0001, 72};
`ifdef HAAR_ARB_FIXED_PRIORITY_EN
    tbl[1] = '{4'b1111, 72, 4'b0001, 72};
    tbl[2] = '{4'b1111, 72, 4'b0001, 72};
    tbl[3] = '{4'b1111, 72, 4'b0001, 72};
    tbl[4] = '{4'b1111, 72, 4'b0001, 72};
    tbl[5] = '{4'b0100, 10, 4'b0100, 10};
    tbl[6] = '{4'b1001, 72, 4'b0001, 72};
    tbl[7] = '{4'b0011,  0, 4'b0001,  0};
    tbl[8] = '{4'b0011,  5, 4'b0001,  5};
`else
    tbl[1] = '{4'b1111, 72, 4'b0010, 72};
    tbl[2] = '{4'b1111, 72, 4'b0100, 72};
    tbl[3] = '{4'b1111, 72, 4'b1000, 72};
    tbl[4] = '{4'b1111, 72, 4'b0001, 72};
    tbl[5] = '{4'b0100, 10, 4'b0100, 10};
    tbl[6] = '{4'b1001, 72, 4'b1000, 72};
    tbl[7] = '{4'b0011,  0, 4'b0001,  0};
    tbl[8] = '{4'b0011,  5, 4'b0010,  5};
`endif
    repeat (2) @(negedge clk);
    chk("rst_outputs", {o_grant, o_rom_ren, o_rom_addr, o_data_valid, o_busy}, 0);
    reset = 1'b0;

    // Latency and turnaround with a single held request
    @(negedge clk); req = 4'b0001;
    tick();
    chk("A_grant", o_grant, 4'b0001);
    chk("A_rd0", {o_rom_ren, o_rom_addr}, {1'b1, 12'd0});
    chk("A_valid_n1", o_data_valid, 0);
    chk("A_busy", o_busy, 1);
    tick();
    chk("A_valid_n2", {o_data_valid, o_index_database}, {1'b1, 12'd0});
    chk("A_addr1", o_rom_addr, 1);
    repeat (70) tick();
    chk("A_rd71", {o_rom_ren, o_rom_addr}, {1'b1, 12'd71});
    tick();
    chk("A_drain_ren", o_rom_ren, 0);
    chk("A_drain_last", {o_data_valid, o_end_database, o_index_database}, {2'b11, 12'd71});
    chk("A_drain_grant", {o_busy, o_grant}, {1'b1, 4'b0001});
    tick();
    chk("A_release", {o_busy, o_grant, o_data_valid}, {1'b1, 4'b0000, 1'b0});
    tick();
    chk("A_idle", {o_busy, o_grant}, 0);
    tick();
    chk("A_regrant", o_grant, 4'b0001);
    @(negedge clk); req = 4'b0000;
    wait_idle("A_end", 20);

    // Reset during word 30, then restart from requester 0 at address 0
    do_reset();
    @(negedge clk); req = 4'b0001;
    wait_grant("B", 20);
    begin
      int n = 0;
      while (!(o_data_valid && o_index_database == 12'd30) && n < 100) begin tick(); n++; end
      chk("B_reach30", n < 100, 1);
    end
    reset = 1'b1;
    #1;
    chk("B_rst_grant", o_grant, 0);
    chk("B_rst_rd", {o_rom_ren, o_rom_addr}, 0);
    chk("B_rst_data", {o_data_valid, o_data}, 0);
    chk("B_rst_idx", {o_index_database, o_index_classifier, o_index_tree}, 0);
    chk("B_rst_flags", {o_end_single_classifier, o_end_tree, o_end_database, o_busy}, 0);
    req = 4'b0011;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    wait_grant("B2", 20);
    chk("B2_grant", o_grant, 4'b0001);
    chk("B2_addr0", o_rom_addr, 0);
    tick();
    chk("B2_first", {o_data_valid, o_index_database}, {1'b1, 12'd0});
    @(negedge clk); req = 4'b0000;
    wait_idle("B_end", 20);

    // Requester 1 arrives mid-stream and must wait for the release
    do_reset();
    @(negedge clk); req = 4'b0001;
    wait_grant("C", 20);
    @(negedge clk); req = 4'b0011;
    begin
      int bad = 0;
      repeat (72) begin tick(); if (o_grant != 4'b0001) bad++; end
      chk("C_hold_grant", bad, 0);
    end
    @(negedge clk); req = 4'b0010;
    tick();
    chk("C_release", o_grant, 0);
    wait_grant("C2", 20);
    chk("C2_grant", o_grant, 4'b0010);
    @(negedge clk); req = 4'b0000;
    wait_idle("C_end", 20);

    // Session table from a fresh reset
    do_reset();
    last = 3;
    for (int i = 0; i < 9; i++) begin
      run_session($sformatf("T%0d", i), tbl[i].req, tbl[i].hold, tbl[i].exp_grant, tbl[i].exp_words);
      last = pick(tbl[i].exp_grant, -1);
    end

    // Random sessions against the arbitration model
    for (int i = 0; i < 25; i++) begin
      logic [3:0] m;
      int hold, e;
      m    = 4'($urandom_range(1, 15));
      hold = ($urandom_range(0, 1) == 1) ? TOTAL : int'($urandom_range(0, TOTAL - 1));
      e    = pick(m, last);
      run_session($sformatf("R%0d", i), m, hold, 4'(1 << e), hold);
      last = e;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
